clk_tick_gen: RTL and testbench
===============================

Name: clk_tick_gen

Overview:
- Parametrised multi-channel clock-enable generator; the successor to the single fixed free-running divider that toggles a slow clock.
- Produces N_CH independent 1-cycle tick strobes and 50%-duty square outputs, all in the i_clk domain. No derived clocks are generated.
- Per-channel divisors are runtime-writable, per-channel enables are provided, and a global phase-sync input is provided.
- Sits between the board clock and the CPU, LED and pin logic, which gate on the ticks.

Parameters:
- CLK_HZ, 16_000_000: input clock frequency; used only to compute the reset divisor.
- TICK_HZ, 100: reset-time square-output frequency per channel.
- N_CH, 4: number of channels, 1..16.
- DIV_W, 32: divisor and counter width.
- Derived localparam DEFAULT_DIV = CLK_HZ/(2*TICK_HZ) - 1 (79999 at defaults). DEFAULT_DIV must fit in DIV_W.
- Derived localparam CH_W = max(1, clog2(N_CH)).

Ports:
- i_clk, in, 1: single clock.
- i_reset, in, 1: asynchronous, active-high reset.
- i_wr_en, in, 1: divisor write strobe.
- i_wr_ch, in, CH_W: channel addressed by the write.
- i_wr_div, in, DIV_W: new divisor value.
- i_ch_en, in, N_CH: per-channel run enable, level-sensitive.
- i_sync, in, 1: global phase realign strobe.
- o_tick, out, N_CH: 1-cycle strobe at each terminal count.
- o_square, out, N_CH: toggles at each tick.

Behaviour:
- Reset (async assert; release synchronous to i_clk):
  - all cnt[ch] = 0
  - all div[ch] = DEFAULT_DIV
  - o_tick = 0, o_square = 0
- Per channel, each cycle with i_ch_en[ch] = 1 and no higher-priority event:
  - If cnt == div: cnt <= 0, o_tick[ch] <= 1, o_square[ch] <= ~o_square[ch].
  - Else: cnt <= cnt + 1, o_tick[ch] <= 0.
- Periods:
  - Tick period is div+1 cycles.
  - Square period is 2*(div+1) cycles.
  - div = 0: tick every cycle, square toggles every cycle.
- Outputs are registered. The tick is asserted the cycle after the counter value equals div.
- First tick after reset or sync: o_tick high in cycle div+1, counting the first enabled edge as cycle 0.
- Disabled channel (i_ch_en[ch] = 0): cnt and o_square hold, o_tick = 0. Re-enable resumes from the held count.
- Divisor write (i_wr_en = 1, i_wr_ch < N_CH):
  - div[i_wr_ch] <= i_wr_div
  - cnt[i_wr_ch] <= 0
  - o_tick[i_wr_ch] <= 0; o_square unchanged
  - The write takes effect even if the channel is disabled.
- Write with i_wr_ch >= N_CH: ignored, no state change.
- i_sync = 1: for every channel, cnt <= 0, o_tick <= 0, o_square <= 0. Divisors are kept. Sync applies regardless of enable.
- Priority per channel (highest first): reset > sync > write > enable/count.
  - Write and terminal count in the same cycle: the write wins and no tick is emitted.
  - Sync and write in the same cycle: the divisor is updated, and cnt and square are cleared.
- Counter never exceeds div in normal operation.
  - No wrap-around at 2^DIV_W; a div of all-ones yields a period of 2^DIV_W.
  - Defensive rule: if cnt > div, treat it as terminal count.
- Channels are fully independent apart from the shared sync and write port.
- Reset mid-count: outputs clear immediately (async) and divisors return to DEFAULT_DIV.

Test Plan:
- Reset default: CLK_HZ=1000, TICK_HZ=100 (DEFAULT_DIV=4), all enabled -> o_tick pulses every 5 cycles, o_square period 10 cycles, all channels in phase.
- Write: write ch1 div=2 mid-count, other channels untouched -> ch1 ticks 3 cycles after the write then every 3 cycles; ch0 keeps its 5-cycle cadence.
- Write/terminal collision: write ch0 div=4 in the cycle ch0 cnt == 4 -> no tick that cycle; next ch0 tick 5 cycles later.
- Enable hold: drop i_ch_en[2] at cnt=2 for 7 cycles, then re-enable -> no ticks while low, square frozen, first tick 3 enabled cycles after re-enable.
- Sync and out-of-range write: pulse i_sync with channels at differing phases -> all squares 0 and all channels tick together div+1 cycles later. A write to i_wr_ch=N_CH -> no divisor change.
- Async reset mid-operation: assert i_reset between clock edges -> o_tick and o_square 0 immediately; divisors back to DEFAULT_DIV after release.

Source files
------------

// File: rtl/clk_tick_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : clk_tick_gen_if
//  Description : Control/status bundle for clk_tick_gen. Carries the divisor
//                write port, per-channel enables, the global sync strobe and
//                the tick/square outputs.
//                  i_wr_en   - divisor write strobe
//                  i_wr_ch   - channel addressed by the write (CH_W bits)
//                  i_wr_div  - new divisor value (DIV_W bits)
//                  i_ch_en   - per-channel run enable, level-sensitive
//                  i_sync    - global phase realign strobe
//                  o_tick    - per-channel 1-cycle strobe at terminal count
//                  o_square  - per-channel 50% square, toggles at each tick
//                master : the controlling side (drives i_*, reads o_*)
//                slave  : the generator itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface clk_tick_gen_if #(
  parameter int N_CH  = 4,
  parameter int DIV_W = 32,
  parameter int CH_W  = 2
);

  logic             i_wr_en;
  logic [CH_W-1:0]  i_wr_ch;
  logic [DIV_W-1:0] i_wr_div;
  logic [N_CH-1:0]  i_ch_en;
  logic             i_sync;
  logic [N_CH-1:0]  o_tick;
  logic [N_CH-1:0]  o_square;

  modport master (
    output i_wr_en, i_wr_ch, i_wr_div, i_ch_en, i_sync,
    input  o_tick, o_square
  );

  modport slave (
    input  i_wr_en, i_wr_ch, i_wr_div, i_ch_en, i_sync,
    output o_tick, o_square
  );

endinterface
`default_nettype wire

// File: rtl/clk_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : clk_tick_gen
//  Description : Multi-channel clock-enable generator. Each channel counts
//                0..div and emits a registered 1-cycle tick plus a 50%-duty
//                square output, all in the i_clk domain (no derived clocks).
//                Divisors are runtime-writable; a global sync realigns all
//                channels to phase zero.
//  Ports       : i_clk   - single clock
//                i_reset - asynchronous active-high reset
//                bus     - clk_tick_gen_if.slave (write port, enables, sync,
//                          tick and square outputs)
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_tick_gen #(
  parameter int CLK_HZ  = 16_000_000,
  parameter int TICK_HZ = 100,
  parameter int N_CH    = 4,
  parameter int DIV_W   = 32
) (
  input  wire            i_clk,
  input  wire            i_reset,
  clk_tick_gen_if.slave  bus
);

  localparam int               CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(CLK_HZ / (2 * TICK_HZ) - 1);

  logic [N_CH-1:0] w_tick;
  logic [N_CH-1:0] w_square;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic             r_tick;
    logic             r_square;
    logic             w_wr_hit;

    // A write addressed beyond N_CH-1 cannot match any generated channel,
    // so out-of-range writes fall out naturally as no-ops.
    assign w_wr_hit = bus.i_wr_en && (bus.i_wr_ch == CH_W'(ch));

    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        r_cnt    <= '0;
        r_div    <= DEFAULT_DIV;
        r_tick   <= 1'b0;
        r_square <= 1'b0;
      end else if (bus.i_sync) begin
        // Sync realigns phase; a coincident write still lands its divisor.
        r_cnt    <= '0;
        r_tick   <= 1'b0;
        r_square <= 1'b0;
        if (w_wr_hit) begin
          r_div <= bus.i_wr_div;
        end
      end else if (w_wr_hit) begin
        // Restart the period; square keeps its level across the write.
        r_div  <= bus.i_wr_div;
        r_cnt  <= '0;
        r_tick <= 1'b0;
      end else if (bus.i_ch_en[ch]) begin
        // '>=' rather than '==' so a counter somehow above div recovers
        // at once instead of running the long way round.
        if (r_cnt >= r_div) begin
          r_cnt    <= '0;
          r_tick   <= 1'b1;
          r_square <= ~r_square;
        end else begin
          r_cnt  <= r_cnt + DIV_W'(1);
          r_tick <= 1'b0;
        end
      end else begin
        r_tick <= 1'b0;
      end
    end

    assign w_tick[ch]   = r_tick;
    assign w_square[ch] = r_square;
  end

  assign bus.o_tick   = w_tick;
  assign bus.o_square = w_square;

endmodule
`default_nettype wire

// File: tb/tb_clk_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_tick_gen
//  Description : Self-checking bench for clk_tick_gen (N_CH=3, DIV_W=8,
//                DEFAULT_DIV=4). Every cycle the DUT is compared against a
//                behavioural model that tracks enabled cycles since the last
//                restart and derives tick/square arithmetically. A vector
//                table and directed sequences cover the corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_tick_gen;

  localparam int N_CH  = 3;
  localparam int DIV_W = 8;
  localparam int CH_W  = 2;
  localparam int DEF_DIV = 1000 / (2 * 100) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  clk_tick_gen_if #(.N_CH(N_CH), .DIV_W(DIV_W), .CH_W(CH_W)) bus ();

  clk_tick_gen #(
    .CLK_HZ (1000),
    .TICK_HZ(100),
    .N_CH   (N_CH),
    .DIV_W  (DIV_W)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: enabled cycles since last restart, divisor, square level at
  // restart, and the resulting outputs.
  longint el   [N_CH];
  longint mdiv [N_CH];
  bit     base [N_CH];
  bit     mtick[N_CH];
  bit     msq  [N_CH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N_CH-1:0] m_tick_vec();
    logic [N_CH-1:0] v;
    for (int c = 0; c < N_CH; c++) v[c] = mtick[c];
    return v;
  endfunction

  function automatic logic [N_CH-1:0] m_sq_vec();
    logic [N_CH-1:0] v;
    for (int c = 0; c < N_CH; c++) v[c] = msq[c];
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      el[c] = 0; mdiv[c] = DEF_DIV; base[c] = 1'b0; mtick[c] = 1'b0; msq[c] = 1'b0;
    end
  endtask

  task automatic model_update();
    for (int c = 0; c < N_CH; c++) begin
      bit hit;
      longint p;
      hit = bus.i_wr_en && (int'(bus.i_wr_ch) == c);
      if (bus.i_sync) begin
        el[c] = 0; mtick[c] = 0; msq[c] = 0; base[c] = 0;
        if (hit) mdiv[c] = longint'(bus.i_wr_div);
      end else if (hit) begin
        mdiv[c] = longint'(bus.i_wr_div); el[c] = 0; mtick[c] = 0; base[c] = msq[c];
      end else if (bus.i_ch_en[c]) begin
        el[c]++;
        p = mdiv[c] + 1;
        mtick[c] = (el[c] % p) == 0;
        msq[c]   = base[c] ^ ((el[c] / p) % 2 == 1);
      end else begin
        mtick[c] = 0;
      end
    end
  endtask

  // One clock: model sees the same inputs as the DUT edge, then compare.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("model_tick",   32'(bus.o_tick),   32'(m_tick_vec()));
    check("model_square", 32'(bus.o_square), 32'(m_sq_vec()));
  endtask

  task automatic idle_inputs();
    bus.i_wr_en = 0; bus.i_wr_ch = '0; bus.i_wr_div = '0;
    bus.i_ch_en = '1; bus.i_sync = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    check("reset_tick_async",   32'(bus.o_tick),   32'(0));
    check("reset_square_async", 32'(bus.o_square), 32'(0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write(input int ch, input int div);
    bus.i_wr_en = 1; bus.i_wr_ch = CH_W'(ch); bus.i_wr_div = DIV_W'(div);
    step();
    bus.i_wr_en = 0;
  endtask

  typedef struct {
    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [DIV_W-1:0] wr_div;
    logic [N_CH-1:0]  ch_en;
    logic             sync;
    logic [N_CH-1:0]  exp_tick;
    logic [N_CH-1:0]  exp_sq;
  } vec_t;

  vec_t tbl[21];

  initial begin
    int t1;
    idle_inputs();

    // ---------------- vector table: default cadence, oob write, sync
    for (int i = 0; i < 21; i++) tbl[i] = '{1'b0, 2'd0, 8'd0, 3'b111, 1'b0, 3'b000, 3'b000};
    tbl[4].exp_tick  = 3'b111;
    for (int i = 4; i <= 8; i++) tbl[i].exp_sq = 3'b111;
    tbl[9].exp_tick  = 3'b111;
    tbl[10].wr_en = 1'b1; tbl[10].wr_ch = 2'd3; tbl[10].wr_div = 8'd0;
    tbl[14].exp_tick = 3'b111; tbl[14].exp_sq = 3'b111;
    tbl[15].sync = 1'b1;
    tbl[20].exp_tick = 3'b111; tbl[20].exp_sq = 3'b111;

    do_reset();
    for (int i = 0; i < 21; i++) begin
      bus.i_wr_en = tbl[i].wr_en; bus.i_wr_ch = tbl[i].wr_ch; bus.i_wr_div = tbl[i].wr_div;
      bus.i_ch_en = tbl[i].ch_en; bus.i_sync = tbl[i].sync;
      step();
      check($sformatf("tbl_tick[%0d]", i), 32'(bus.o_tick),   32'(tbl[i].exp_tick));
      check($sformatf("tbl_sq[%0d]", i),   32'(bus.o_square), 32'(tbl[i].exp_sq));
    end
    idle_inputs();

    // ---------------- write ch1 div=2 mid-count; ch1 ticks 3 cycles later
    do_reset();
    step(); step();
    write(1, 2);
    t1 = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      t1 += int'(bus.o_tick[1]);
      if (i == 2) check("wr_ch1_first_tick", 32'(bus.o_tick[1]), 32'(1));
    end
    check("wr_ch1_tick_count", 32'(t1), 32'(3));

    // ---------------- write/terminal collision on ch0
    do_reset();
    for (int i = 0; i < 4; i++) step();
    write(0, 4);
    check("collision_no_tick_ch0", 32'(bus.o_tick[0]), 32'(0));
    check("collision_tick_ch2",    32'(bus.o_tick[2]), 32'(1));
    for (int i = 0; i < 5; i++) step();
    check("collision_next_tick", 32'(bus.o_tick[0]), 32'(1));

    // ---------------- enable hold on ch2 at cnt=2
    do_reset();
    step(); step();
    bus.i_ch_en = 3'b011;
    for (int i = 0; i < 7; i++) step();
    bus.i_ch_en = 3'b111;
    step(); step(); step();
    check("reenable_tick_ch2", 32'(bus.o_tick[2]), 32'(1));
    for (int i = 0; i < 4; i++) step();

    // ---------------- sync with channels at differing phases
    write(0, 6); step(); write(1, 3); step(); step();
    bus.i_sync = 1; step(); bus.i_sync = 0;
    check("sync_square_zero", 32'(bus.o_square), 32'(0));
    write(2, 6);
    for (int i = 0; i < 12; i++) step();
    // sync + write same cycle
    bus.i_sync = 1; bus.i_wr_en = 1; bus.i_wr_ch = 2'd1; bus.i_wr_div = 8'd1;
    step();
    idle_inputs();
    step(); step();
    check("sync_write_div1", 32'(bus.o_tick[1]), 32'(1));

    // ---------------- randomized traffic
    for (int i = 0; i < 2500; i++) begin
      bus.i_wr_en  = ($urandom_range(0, 19) == 0);
      bus.i_wr_ch  = CH_W'($urandom_range(0, 3));
      bus.i_wr_div = ($urandom_range(0, 15) == 0) ? 8'hFF : DIV_W'($urandom_range(0, 9));
      for (int c = 0; c < N_CH; c++) bus.i_ch_en[c] = ($urandom_range(0, 7) != 0);
      bus.i_sync   = ($urandom_range(0, 59) == 0);
      step();
    end
    // long all-ones period on ch0
    idle_inputs();
    write(0, 255);
    for (int i = 0; i < 520; i++) step();

    // ---------------- async reset mid-operation
    write(1, 0);
    step(); step(); step();
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_tick",   32'(bus.o_tick),   32'(0));
    check("async_reset_square", 32'(bus.o_square), 32'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
